// File: rtl/bram_wb_banked.sv
// Banked byte-lane dual-port BRAM: Wishbone slave plus free-running fabric port.
// Define BRAM_WB_MBOX_IRQ_EN to build the fabric-to-host mailbox interrupt.
module bram_wb_banked #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 8,
  parameter int NUM_BANKS   = 4,
  parameter int WAIT_STATES = 1,
  localparam int NLANES     = DATA_WIDTH / 8,
  localparam int BANK_BITS  = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
  input  logic                           wbs_clk_i,
  input  logic                           wbs_rst_n_i,
  input  logic                           fabric_we,
  input  logic [BANK_BITS-1:0]           fabric_bank,
  input  logic [ADDR_WIDTH-1:0]          fabric_addr,
  input  logic [DATA_WIDTH-1:0]          fabric_data_in,
  output logic [DATA_WIDTH-1:0]          fabric_data_out,
  input  logic                           wbs_cyc_i,
  input  logic                           wbs_stb_i,
  input  logic                           wbs_we_i,
  input  logic [NLANES-1:0]              wbs_sel_i,
  input  logic [BANK_BITS+ADDR_WIDTH-1:0] wbs_adr_i,
  input  logic [DATA_WIDTH-1:0]          wbs_dat_i,
  output logic [DATA_WIDTH-1:0]          wbs_dat_o,
  output logic                           wbs_ack_o,
  output logic                           wbs_int_o
);

  localparam int AW    = BANK_BITS + ADDR_WIDTH;
  localparam int DEPTH = 2 ** AW;
  // A single bank leaves the bank bit unused, so fold it away.
  localparam logic [AW-1:0] AMASK =
    AW'(NUM_BANKS * (2 ** ADDR_WIDTH) - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_WAIT,
    S_ACK
  } state_e;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  state_e                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [AW-1:0]         adr_q, adr_d;
  logic                  we_q, we_d;
  logic [NLANES-1:0]     sel_q, sel_d;
  logic [DATA_WIDTH-1:0] wdat_q, wdat_d;
  logic [DATA_WIDTH-1:0] rd_q, rd_d;
  logic [DATA_WIDTH-1:0] dato_q, dato_d;
  logic                  ack_q, ack_d;
  logic [DATA_WIDTH-1:0] fdo_q, fdo_d;

  logic [AW-1:0] fab_idx;
  logic          wb_wr;

  assign fab_idx = {fabric_bank, fabric_addr} & AMASK;
  assign wb_wr   = (state_q == S_ACCESS) && we_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    adr_d   = adr_q;
    we_d    = we_q;
    sel_d   = sel_q;
    wdat_d  = wdat_q;
    rd_d    = rd_q;
    dato_d  = dato_q;
    ack_d   = 1'b0;
    fdo_d   = mem[fab_idx];
    unique case (state_q)
      S_IDLE: begin
        if (wbs_cyc_i && wbs_stb_i) begin
          adr_d   = wbs_adr_i & AMASK;
          we_d    = wbs_we_i;
          sel_d   = wbs_sel_i;
          wdat_d  = wbs_dat_i;
          state_d = S_ACCESS;
        end
      end
      S_ACCESS: begin
        // Read word is sampled here, before any write lands (read-first).
        rd_d = mem[adr_q];
        if (!wbs_cyc_i) begin
          state_d = S_IDLE;
        end else if (WAIT_STATES == 0) begin
          state_d = S_ACK;
        end else begin
          cnt_d   = 4'(WAIT_STATES);
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (!wbs_cyc_i) begin
          cnt_d   = 4'd0;
          state_d = S_IDLE;
        end else if (cnt_q <= 4'd1) begin
          cnt_d   = 4'd0;
          state_d = S_ACK;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_ACK: begin
        ack_d   = 1'b1;
        state_d = S_IDLE;
        if (!we_q) begin
          dato_d = rd_q;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge wbs_clk_i or negedge wbs_rst_n_i) begin
    if (!wbs_rst_n_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      adr_q   <= '0;
      we_q    <= 1'b0;
      sel_q   <= '0;
      wdat_q  <= '0;
      rd_q    <= '0;
      dato_q  <= '0;
      ack_q   <= 1'b0;
      fdo_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      adr_q   <= adr_d;
      we_q    <= we_d;
      sel_q   <= sel_d;
      wdat_q  <= wdat_d;
      rd_q    <= rd_d;
      dato_q  <= dato_d;
      ack_q   <= ack_d;
      fdo_q   <= fdo_d;
    end
  end

  // Per lane: an enabled Wishbone lane beats the fabric on the same word.
  always_ff @(posedge wbs_clk_i) begin
    for (int i = 0; i < NLANES; i++) begin
      if (wb_wr && sel_q[i]) begin
        mem[adr_q][8*i +: 8] <= wdat_q[8*i +: 8];
      end
      if (fabric_we &&
          !(wb_wr && sel_q[i] && (adr_q == fab_idx))) begin
        mem[fab_idx][8*i +: 8] <= fabric_data_in[8*i +: 8];
      end
    end
  end

  assign wbs_ack_o       = ack_q;
  assign wbs_dat_o       = dato_q;
  assign fabric_data_out = fdo_q;

`ifdef BRAM_WB_MBOX_IRQ_EN
  localparam logic [AW-1:0] MBOX = AMASK;

  logic int_q, int_d;

  always_comb begin
    int_d = int_q;
    if ((state_q == S_ACK) && !we_q && (adr_q == MBOX)) begin
      int_d = 1'b0;
    end
    if (fabric_we && (fab_idx == MBOX)) begin
      int_d = 1'b1;
    end
  end

  always_ff @(posedge wbs_clk_i or negedge wbs_rst_n_i) begin
    if (!wbs_rst_n_i) begin
      int_q <= 1'b0;
    end else begin
      int_q <= int_d;
    end
  end

  assign wbs_int_o = int_q;
`else
  assign wbs_int_o = 1'b0;
`endif

endmodule

// File: tb/tb_bram_wb_banked.sv
// Bench for bram_wb_banked: two instances (0 and 3 wait states) checked
// against a word-array model of the memory and the cycle-level timing rules.
module tb_bram_wb_banked;

`ifdef BRAM_WB_MBOX_IRQ_EN
  localparam bit IRQ = 1'b1;
`else
  localparam bit IRQ = 1'b0;
`endif

  logic clk;
  logic rst_n;

  logic        fwe   [2];
  logic [1:0]  fbank [2];
  logic [7:0]  faddr [2];
  logic [31:0] fdin  [2];
  logic [31:0] fdo   [2];
  logic        cyc   [2];
  logic        stb   [2];
  logic        we    [2];
  logic [3:0]  sel   [2];
  logic [9:0]  adr   [2];
  logic [31:0] dati  [2];
  logic [31:0] dato  [2];
  logic        ack   [2];
  logic        irq   [2];

  logic [31:0] mdl [2][1024];

  int n_tests;
  int n_fail;

  bram_wb_banked #(
    .DATA_WIDTH(32), .ADDR_WIDTH(8),
    .NUM_BANKS(4), .WAIT_STATES(0)
  ) u_dut0 (
    .wbs_clk_i(clk), .wbs_rst_n_i(rst_n),
    .fabric_we(fwe[0]), .fabric_bank(fbank[0]),
    .fabric_addr(faddr[0]), .fabric_data_in(fdin[0]),
    .fabric_data_out(fdo[0]),
    .wbs_cyc_i(cyc[0]), .wbs_stb_i(stb[0]), .wbs_we_i(we[0]),
    .wbs_sel_i(sel[0]), .wbs_adr_i(adr[0]), .wbs_dat_i(dati[0]),
    .wbs_dat_o(dato[0]), .wbs_ack_o(ack[0]), .wbs_int_o(irq[0])
  );

  bram_wb_banked #(
    .DATA_WIDTH(32), .ADDR_WIDTH(8),
    .NUM_BANKS(4), .WAIT_STATES(3)
  ) u_dut3 (
    .wbs_clk_i(clk), .wbs_rst_n_i(rst_n),
    .fabric_we(fwe[1]), .fabric_bank(fbank[1]),
    .fabric_addr(faddr[1]), .fabric_data_in(fdin[1]),
    .fabric_data_out(fdo[1]),
    .wbs_cyc_i(cyc[1]), .wbs_stb_i(stb[1]), .wbs_we_i(we[1]),
    .wbs_sel_i(sel[1]), .wbs_adr_i(adr[1]), .wbs_dat_i(dati[1]),
    .wbs_dat_o(dato[1]), .wbs_ack_o(ack[1]), .wbs_int_o(irq[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int ws(input int k);
    return (k == 0) ? 0 : 3;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old,
                                        input logic [31:0] nw,
                                        input logic [3:0]  s);
    logic [31:0] m;
    m = old;
    for (int i = 0; i < 4; i++)
      if (s[i]) m[8*i +: 8] = nw[8*i +: 8];
    return m;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fab_write(input int k, input logic [1:0] b,
                           input logic [7:0] a, input logic [31:0] d);
    fwe[k] = 1'b1; fbank[k] = b; faddr[k] = a; fdin[k] = d;
    tick();
    fwe[k] = 1'b0;
    mdl[k][int'({b, a})] = d;
  endtask

  task automatic fab_read(input int k, input logic [1:0] b,
                          input logic [7:0] a, output logic [31:0] r);
    fbank[k] = b; faddr[k] = a;
    tick();
    r = fdo[k];
  endtask

  // Drives one Wishbone transfer; lat is the edge count from the sampling
  // edge to the edge after which ack is seen (-1 on timeout).
  task automatic wb_xfer(input int k, input logic w, input logic [9:0] a,
                         input logic [3:0] s, input logic [31:0] d,
                         output logic [31:0] r, output int lat);
    cyc[k] = 1'b1; stb[k] = 1'b1; we[k] = w;
    adr[k] = a; sel[k] = s; dati[k] = d;
    lat = -1; r = '0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (ack[k]) begin
        lat = c;
        r = dato[k];
        break;
      end
    end
    cyc[k] = 1'b0; stb[k] = 1'b0; we[k] = 1'b0;
    if (lat < 0) begin
      n_tests++; n_fail++;
      $display("FAIL wb_timeout dut%0d: no ack within 40 cycles", k);
    end
    if (w) mdl[k][int'(a)] = merge(mdl[k][int'(a)], d, s);
    tick();
  endtask

  task automatic test_reset();
    #2;
    for (int k = 0; k < 2; k++) begin
      n_tests++;
      if (ack[k] !== 1'b0 || dato[k] !== 32'h0 ||
          irq[k] !== 1'b0 || fdo[k] !== 32'h0) begin
        n_fail++;
        $display("FAIL reset_state dut%0d: ack=%b dat=%h int=%b fdo=%h want 0 0 0 0",
                 k, ack[k], dato[k], irq[k], fdo[k]);
      end
    end
    #20 rst_n = 1'b1;
    tick();
  endtask

  task automatic test_latency();
    logic [31:0] r, f, prev;
    int lat;
    for (int k = 0; k < 2; k++) begin
      prev = dato[k];
      wb_xfer(k, 1'b1, {2'd2, 8'h10}, 4'hF, 32'hDEADBEEF, r, lat);
      n_tests++;
      if (lat !== 2 + ws(k) || r !== prev) begin
        n_fail++;
        $display("FAIL wr_latency dut%0d: lat=%0d dat=%h want %0d %h",
                 k, lat, r, 2 + ws(k), prev);
      end
      wb_xfer(k, 1'b0, {2'd2, 8'h10}, 4'h0, 32'h0, r, lat);
      n_tests++;
      if (lat !== 2 + ws(k) || r !== 32'hDEADBEEF) begin
        n_fail++;
        $display("FAIL rd_latency dut%0d: lat=%0d dat=%h want %0d deadbeef",
                 k, lat, r, 2 + ws(k));
      end
      fab_read(k, 2'd2, 8'h10, f);
      n_tests++;
      if (f !== 32'hDEADBEEF) begin
        n_fail++;
        $display("FAIL fab_read dut%0d: got %h want deadbeef", k, f);
      end
    end
  endtask

  task automatic test_byte_lanes();
    logic [31:0] r;
    int lat;
    for (int k = 0; k < 2; k++) begin
      fab_write(k, 2'd0, 8'h05, 32'h11223344);
      wb_xfer(k, 1'b1, {2'd0, 8'h05}, 4'b0101, 32'hAABBCCDD, r, lat);
      wb_xfer(k, 1'b0, {2'd0, 8'h05}, 4'h0, 32'h0, r, lat);
      n_tests++;
      if (r !== 32'h11BB33DD) begin
        n_fail++;
        $display("FAIL byte_lanes dut%0d: got %h want 11bb33dd", k, r);
      end
      wb_xfer(k, 1'b1, {2'd0, 8'h05}, 4'h0, 32'hFFFFFFFF, r, lat);
      n_tests++;
      if (lat !== 2 + ws(k)) begin
        n_fail++;
        $display("FAIL sel0_ack dut%0d: lat=%0d want %0d", k, lat, 2 + ws(k));
      end
      wb_xfer(k, 1'b0, {2'd0, 8'h05}, 4'hF, 32'h0, r, lat);
      n_tests++;
      if (r !== 32'h11BB33DD) begin
        n_fail++;
        $display("FAIL sel0_write dut%0d: got %h want 11bb33dd", k, r);
      end
    end
  endtask

  task automatic test_collision();
    logic [31:0] r, f;
    int lat;
    bit got;
    for (int k = 0; k < 2; k++) begin
      fab_write(k, 2'd1, 8'h07, 32'h12345678);
      cyc[k] = 1'b1; stb[k] = 1'b1; we[k] = 1'b1;
      adr[k] = {2'd1, 8'h07}; sel[k] = 4'b1100; dati[k] = 32'hFFFFFFFF;
      tick();
      // The Wishbone write commits on the following edge.
      fwe[k] = 1'b1; fbank[k] = 2'd1; faddr[k] = 8'h07; fdin[k] = 32'h0;
      tick();
      fwe[k] = 1'b0;
      got = 1'b0;
      for (int c = 0; c < 20 && !got; c++) begin
        if (ack[k]) got = 1'b1;
        else tick();
      end
      cyc[k] = 1'b0; stb[k] = 1'b0; we[k] = 1'b0;
      tick();
      mdl[k][int'({2'd1, 8'h07})] = 32'hFFFF0000;
      wb_xfer(k, 1'b0, {2'd1, 8'h07}, 4'h0, 32'h0, r, lat);
      fab_read(k, 2'd1, 8'h07, f);
      n_tests++;
      if (!got || r !== 32'hFFFF0000 || f !== 32'hFFFF0000) begin
        n_fail++;
        $display("FAIL collision dut%0d: ack=%b wb=%h fab=%h want 1 ffff0000",
                 k, got, r, f);
      end
    end
  endtask

  task automatic test_abort();
    logic [31:0] r;
    int lat;
    bit seen;
    fab_write(1, 2'd1, 8'h30, 32'h0);
    cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1;
    adr[1] = {2'd1, 8'h30}; sel[1] = 4'hF; dati[1] = 32'h5A5A5A5A;
    tick();
    tick();
    cyc[1] = 1'b0; stb[1] = 1'b0; we[1] = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (ack[1]) seen = 1'b1;
      tick();
    end
    n_tests++;
    if (seen !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_ack: saw ack=1 want no ack");
    end
    mdl[1][int'({2'd1, 8'h30})] = 32'h5A5A5A5A;
    wb_xfer(1, 1'b0, {2'd1, 8'h30}, 4'h0, 32'h0, r, lat);
    n_tests++;
    if (r !== 32'h5A5A5A5A) begin
      n_fail++;
      $display("FAIL abort_commit: got %h want 5a5a5a5a", r);
    end
  endtask

  task automatic test_back_to_back();
    int acks[$];
    int hold, e1, e2;
    logic [31:0] dats[$];
    for (int k = 0; k < 2; k++) begin
      acks.delete(); dats.delete();
      hold = 2 * (3 + ws(k)) - 1;
      e1 = 2 + ws(k);
      e2 = e1 + 3 + ws(k);
      cyc[k] = 1'b1; stb[k] = 1'b1; we[k] = 1'b0;
      adr[k] = {2'd2, 8'h10}; sel[k] = 4'h0;
      for (int c = 0; c <= hold + 8; c++) begin
        if (c > 0 && ack[k]) begin
          acks.push_back(c - 1);
          dats.push_back(dato[k]);
        end
        if (c == hold + 1) begin
          cyc[k] = 1'b0; stb[k] = 1'b0;
        end
        if (c <= hold + 7) tick();
      end
      n_tests++;
      if (acks.size() != 2 || acks[0] != e1 || acks[1] != e2 ||
          dats[0] !== 32'hDEADBEEF || dats[1] !== 32'hDEADBEEF) begin
        n_fail++;
        $display("FAIL back_to_back dut%0d: %0d acks first=%0d want 2 acks at %0d,%0d",
                 k, acks.size(), (acks.size() > 0) ? acks[0] : -1, e1, e2);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] r, d;
    logic [9:0]  a;
    logic [3:0]  s;
    int lat, k, op;
    for (int kk = 0; kk < 2; kk++)
      for (int b = 0; b < 4; b++)
        for (int j = 0; j < 4; j++)
          fab_write(kk, 2'(b), 8'(8'h20 + j), $urandom);
    for (int it = 0; it < 60; it++) begin
      k  = $urandom_range(0, 1);
      op = $urandom_range(0, 3);
      a  = {2'($urandom_range(0, 3)), 8'(8'h20 + $urandom_range(0, 3))};
      d  = $urandom;
      s  = 4'($urandom_range(0, 15));
      case (op)
        0: fab_write(k, a[9:8], a[7:0], d);
        1: begin
          wb_xfer(k, 1'b1, a, s, d, r, lat);
          n_tests++;
          if (lat !== 2 + ws(k)) begin
            n_fail++;
            $display("FAIL rand_wr_lat dut%0d: lat=%0d want %0d", k, lat, 2 + ws(k));
          end
        end
        2: begin
          wb_xfer(k, 1'b0, a, s, d, r, lat);
          n_tests++;
          if (r !== mdl[k][int'(a)] || lat !== 2 + ws(k)) begin
            n_fail++;
            $display("FAIL rand_wb_rd dut%0d @%h: got %h lat %0d want %h lat %0d",
                     k, a, r, lat, mdl[k][int'(a)], 2 + ws(k));
          end
        end
        default: begin
          fab_read(k, a[9:8], a[7:0], r);
          n_tests++;
          if (r !== mdl[k][int'(a)]) begin
            n_fail++;
            $display("FAIL rand_fab_rd dut%0d @%h: got %h want %h",
                     k, a, r, mdl[k][int'(a)]);
          end
        end
      endcase
    end
  endtask

  task automatic test_reset_midwait();
    bit seen;
    cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b0;
    adr[1] = {2'd2, 8'h10}; sel[1] = 4'hF;
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (ack[1] !== 1'b0 || dato[1] !== 32'h0 || irq[1] !== 1'b0 ||
        fdo[1] !== 32'h0 || dato[0] !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_midwait: ack=%b dat=%h int=%b fdo=%h want 0 0 0 0",
               ack[1], dato[1], irq[1], fdo[1]);
    end
    cyc[1] = 1'b0; stb[1] = 1'b0;
    #3 rst_n = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (ack[1]) seen = 1'b1;
    end
    n_tests++;
    if (seen !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_no_ack: saw ack=1 want none");
    end
  endtask

  task automatic test_mailbox();
    logic [31:0] r;
    int lat;
    n_tests++;
    if (irq[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL mbox_idle: int=%b want 0", irq[0]);
    end
    fab_write(0, 2'd3, 8'hFF, 32'h1);
    n_tests++;
    if (irq[0] !== IRQ) begin
      n_fail++;
      $display("FAIL mbox_set: int=%b want %b", irq[0], IRQ);
    end
    tick();
    tick();
    n_tests++;
    if (irq[0] !== IRQ) begin
      n_fail++;
      $display("FAIL mbox_sticky: int=%b want %b", irq[0], IRQ);
    end
    wb_xfer(0, 1'b0, {2'd3, 8'hFF}, 4'hF, 32'h0, r, lat);
    n_tests++;
    if (r !== 32'h1 || lat !== 2 || irq[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL mbox_read: dat=%h lat=%0d int=%b want 1 2 0",
               r, lat, irq[0]);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    for (int k = 0; k < 2; k++) begin
      fwe[k] = 1'b0; fbank[k] = '0; faddr[k] = '0; fdin[k] = '0;
      cyc[k] = 1'b0; stb[k] = 1'b0; we[k] = 1'b0;
      sel[k] = '0; adr[k] = '0; dati[k] = '0;
    end
    test_reset();
    test_latency();
    test_byte_lanes();
    test_collision();
    test_abort();
    test_back_to_back();
    test_random();
    test_reset_midwait();
    test_mailbox();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
